// File: rtl/harmonic_pkg.sv
// Shared state encoding, routing modes and limit helper for the harmonic scheduler.
package harmonic_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_INIT      = 3'd0;
  localparam logic [STATE_W-1:0] ST_DISPATCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_SCALE     = 3'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN     = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd4;
  localparam logic [STATE_W-1:0] ST_CAPTURE   = 3'd5;
  localparam logic [STATE_W-1:0] ST_CLEAR     = 3'd6;
  localparam logic [STATE_W-1:0] ST_WAIT_TICK = 3'd7;

  localparam logic [1:0] MODE_RR    = 2'd0;
  localparam logic [1:0] MODE_BCAST = 2'd1;
  localparam logic [1:0] MODE_MONO  = 2'd2;

  // Frame harmonic count: runtime request clipped to the build maximum, never zero.
  function automatic logic [7:0] clamp_limit(input logic [7:0] req, input logic [7:0] max_h);
    logic [7:0] lim;
    lim = (req > max_h) ? max_h : req;
    if (lim == 8'd0) lim = 8'd1;
    return lim;
  endfunction

endpackage

// File: rtl/sample_tick_timer.sv
// Free-running sample-rate timer; tick_c is high on the last count of each interval.
module sample_tick_timer #(
  parameter int unsigned SAMPLE_INTERVAL = 1500
) (
  input  logic i_Clock,
  input  logic i_Reset,
  output logic tick_c
);

  localparam int unsigned CNT_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_INTERVAL - 1);

  logic [CNT_W-1:0] count;

  // Count 0..SAMPLE_INTERVAL-1 and wrap.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)            count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CNT_W'(1);
  end

  assign tick_c = (count == LAST);

endmodule

// File: rtl/harmonic_scheduler.sv
// Per-sample frame sequencer: dispatches harmonics to the adders, captures the
// totals and hands them to the DAC on each sample tick.
module harmonic_scheduler
  import harmonic_pkg::*;
#(
  parameter int unsigned NUM_HARMONICS   = 50,
  parameter int unsigned NUM_CHANNELS    = 2,
  parameter int unsigned SAMPLE_INTERVAL = 1500,
  parameter int unsigned ACC_WIDTH       = 32
) (
  input  logic                              i_Clock,
  input  logic                              i_Reset,
  input  logic [1:0]                        i_Mode,
  input  logic [7:0]                        i_Max_Harmonic,
  input  logic                              i_Sample_Ready,
  input  logic                              i_Freq_Too_High,
  input  logic [NUM_CHANNELS-1:0]           i_Adder_Ready,
  input  logic [NUM_CHANNELS*ACC_WIDTH-1:0] i_Adder_Total,
  output logic [7:0]                        o_Harmonic,
  output logic                              o_Next_Sample,
  output logic [NUM_CHANNELS-1:0]           o_Adder_Start,
  output logic                              o_Adder_Clear,
  output logic                              o_Scaler_Start,
  output logic                              o_Scaler_Restart,
  output logic [NUM_CHANNELS*ACC_WIDTH-1:0] o_Sample,
  output logic                              o_Sample_Valid,
  output logic                              o_Overrun,
  output logic [7:0]                        o_Overrun_Count
);

  localparam int unsigned NC = NUM_CHANNELS;
  localparam logic [7:0]  MAX_H = (NUM_HARMONICS > 255) ? 8'd255 : 8'(NUM_HARMONICS);

  logic [STATE_W-1:0] state, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [7:0]         limit_q, limit_d;
  logic [7:0]         harmonic_d, ovr_count_d;
  logic [NC-1:0]      targets_c, start_d;
  logic               ready_ok_c, capture_c, tick_c;
  logic               next_sample_d, clear_d, scaler_start_d, restart_d, valid_d, overrun_d;

  sample_tick_timer #(.SAMPLE_INTERVAL(SAMPLE_INTERVAL)) u_timer (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .tick_c  (tick_c)
  );

  // Target channels for the current harmonic under the latched routing mode.
  always_comb begin
    targets_c = '0;
    case (mode_q)
      MODE_BCAST: targets_c = '1;
      MODE_MONO:  targets_c = NC'(1);
      default:    targets_c = NC'(1) << (o_Harmonic % 8'(NC));
    endcase
    ready_ok_c = &(i_Adder_Ready | ~targets_c);
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d        = state;
    mode_d         = mode_q;
    limit_d        = limit_q;
    harmonic_d     = o_Harmonic;
    next_sample_d  = 1'b0;
    start_d        = '0;
    clear_d        = 1'b0;
    scaler_start_d = 1'b0;
    restart_d      = 1'b0;
    valid_d        = 1'b0;
    capture_c      = 1'b0;
    overrun_d      = tick_c && (state != ST_WAIT_TICK);
    ovr_count_d    = o_Overrun_Count;
    if (overrun_d && (o_Overrun_Count != 8'hFF)) ovr_count_d = o_Overrun_Count + 8'd1;

    case (state)
      ST_INIT: begin
        mode_d     = ((i_Mode == MODE_BCAST) || (i_Mode == MODE_MONO)) ? i_Mode : MODE_RR;
        limit_d    = clamp_limit(i_Max_Harmonic, MAX_H);
        harmonic_d = 8'd0;
        state_d    = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (i_Sample_Ready && ready_ok_c) begin
          next_sample_d = 1'b1;
          start_d       = targets_c;
          harmonic_d    = o_Harmonic + 8'd1;
          state_d       = ((o_Harmonic == limit_q - 8'd1) || i_Freq_Too_High) ? ST_DRAIN : ST_SCALE;
        end
      end
      ST_SCALE: begin
        scaler_start_d = 1'b1;
        state_d        = ST_DISPATCH;
      end
      ST_DRAIN:     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (&i_Adder_Ready) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        capture_c = 1'b1;
        state_d   = ST_CLEAR;
      end
      ST_CLEAR: begin
        clear_d = 1'b1;
        state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (tick_c) begin
          valid_d   = 1'b1;
          restart_d = 1'b1;
          state_d   = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and per-frame latched configuration.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= ST_INIT;
      mode_q  <= MODE_RR;
      limit_q <= 8'd1;
    end else begin
      state   <= state_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
    end
  end

  // Registered outputs; o_Sample only changes on capture.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Harmonic       <= '0;
      o_Next_Sample    <= 1'b0;
      o_Adder_Start    <= '0;
      o_Adder_Clear    <= 1'b0;
      o_Scaler_Start   <= 1'b0;
      o_Scaler_Restart <= 1'b0;
      o_Sample         <= '0;
      o_Sample_Valid   <= 1'b0;
      o_Overrun        <= 1'b0;
      o_Overrun_Count  <= '0;
    end else begin
      o_Harmonic       <= harmonic_d;
      o_Next_Sample    <= next_sample_d;
      o_Adder_Start    <= start_d;
      o_Adder_Clear    <= clear_d;
      o_Scaler_Start   <= scaler_start_d;
      o_Scaler_Restart <= restart_d;
      o_Sample_Valid   <= valid_d;
      o_Overrun        <= overrun_d;
      o_Overrun_Count  <= ovr_count_d;
      if (capture_c) o_Sample <= i_Adder_Total;
    end
  end

endmodule

// File: doc/harmonic_scheduler.md
HARMONIC_SCHEDULER -- requirements
Module: harmonic_scheduler

Interface
REQ-001 SHALL have parameter NUM_HARMONICS, default 50, meaning the compile-time maximum harmonics per frame.
REQ-002 SHALL have parameter NUM_CHANNELS, default 2, meaning the number of adder/output channels (range 1..8).
REQ-003 SHALL have parameter SAMPLE_INTERVAL, default 1500, meaning clocks per output sample (72 MHz / 48 kHz).
REQ-004 SHALL have parameter ACC_WIDTH, default 32, meaning the adder accumulator width.
REQ-005 SHALL have port i_Clock, input, 1, the single system clock.
REQ-006 SHALL have port i_Reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port i_Mode, input, 2, routing mode: 0 round-robin, 1 broadcast, 2 mono (channel 0), 3 treated as 0.
REQ-008 SHALL have port i_Max_Harmonic, input, 8, the runtime harmonic limit.
REQ-009 SHALL have port i_Sample_Ready, input, 1, the sample-position value is valid.
REQ-010 SHALL have port i_Freq_Too_High, input, 1, the current harmonic is above Nyquist.
REQ-011 SHALL have port i_Adder_Ready, input, NUM_CHANNELS, per-channel adder idle flags.
REQ-012 SHALL have port i_Adder_Total, input, NUM_CHANNELS*ACC_WIDTH, per-channel accumulators.
REQ-013 SHALL have port o_Harmonic, output, 8, the harmonic index being requested.
REQ-014 SHALL have port o_Next_Sample, output, 1, a one-clock pulse that advances sample position.
REQ-015 SHALL have port o_Adder_Start, output, NUM_CHANNELS, per-channel one-clock start pulses.
REQ-016 SHALL have ports o_Adder_Clear, o_Scaler_Start and o_Scaler_Restart, output, 1 each, one-clock pulses.
REQ-017 SHALL have port o_Sample, output, NUM_CHANNELS*ACC_WIDTH, the captured totals.
REQ-018 SHALL have port o_Sample_Valid, output, 1, a one-clock DAC start pulse.
REQ-019 SHALL have ports o_Overrun (1, pulse) and o_Overrun_Count (8, saturating), output.

Function
REQ-020 SHALL run a free-running timer 0..SAMPLE_INTERVAL-1 that asserts internal tick when count equals SAMPLE_INTERVAL-1, then wraps to 0.
REQ-021 SHALL implement states INIT, DISPATCH, SCALE, DRAIN, WAIT_DONE, CAPTURE, CLEAR, WAIT_TICK.
REQ-022 SHALL, in INIT, latch mode and limit L = min(i_Max_Harmonic, NUM_HARMONICS) with 0 forced to 1, set o_Harmonic=0, then go to DISPATCH.
REQ-023 SHALL, in DISPATCH when i_Sample_Ready and all target adders are ready, pulse o_Next_Sample and the target bits of o_Adder_Start, and increment o_Harmonic.
REQ-024 SHALL select targets as follows: mode 0 = channel (o_Harmonic mod NUM_CHANNELS); mode 1 = all channels; mode 2 = channel 0.
REQ-025 SHALL, on dispatch, go to DRAIN if o_Harmonic == L-1 or i_Freq_Too_High, else to SCALE.
REQ-026 SHALL, in SCALE, pulse o_Scaler_Start and return to DISPATCH, giving a minimum of 2 clocks per harmonic.
REQ-027 SHALL wait one clock in DRAIN, then wait in WAIT_DONE until all i_Adder_Ready are high.
REQ-028 SHALL, in CAPTURE, register i_Adder_Total into o_Sample, then pulse o_Adder_Clear in CLEAR and enter WAIT_TICK.
REQ-029 SHALL, on tick in WAIT_TICK, pulse o_Sample_Valid and o_Scaler_Restart in the same clock and go to INIT.
REQ-030 SHALL treat a tick in any state other than WAIT_TICK as an overrun: pulse o_Overrun, increment o_Overrun_Count saturating at 255, continue the frame, and hold the previous o_Sample.
REQ-031 SHALL keep o_Sample stable between CAPTURE events.
REQ-032 SHALL ignore i_Mode and i_Max_Harmonic changes mid-frame.
REQ-033 SHALL never assert o_Adder_Start to a channel whose ready flag is low.

Reset
REQ-034 SHALL, on i_Reset at any time, immediately clear all outputs, the timer, o_Harmonic and o_Overrun_Count to 0, and set the state to INIT.
REQ-035 SHALL restart the frame cleanly after reset release, with no pulse emitted on the first clock.

Structure
REQ-036 SHALL take the state encoding and mode constants (MODE_RR, MODE_BCAST, MODE_MONO) from shared package harmonic_pkg.
REQ-037 SHALL place the timer and tick generation in sub-module sample_tick_timer.

Verification
REQ-038 SHALL verify: NUM_CHANNELS=2, mode 0, limit 50, adders always ready -> 50 o_Next_Sample pulses, starts alternating ch0/ch1 (25 each), one o_Sample_Valid per 1500 clocks.
REQ-039 SHALL verify: i_Freq_Too_High asserted at harmonic 10 -> exactly 11 dispatches, then DRAIN.
REQ-040 SHALL verify: mode 1, NUM_CHANNELS=4, limit 3 -> each dispatch has o_Adder_Start=4'b1111, 3 dispatches total.
REQ-041 SHALL verify: adder ready held low 2000 clocks -> o_Overrun pulses once, count=1, o_Sample unchanged.
REQ-042 SHALL verify: i_Max_Harmonic=0 -> 1 dispatch; i_Max_Harmonic=200 -> 50 dispatches.
REQ-043 SHALL verify: i_Reset asserted mid-DISPATCH -> all outputs 0 in the same clock, and a normal frame follows release.
